// File: rtl/eval_arbiter.sv
// Round-robin scheduler that shares one registered evaluator
// Z = (d[0] & d[1]) | d[2] | d[3] among NREQ requesters.
// A transaction takes two cycles: GRANT latches the operand, then ACK presents
// the result. Back-to-back grants skip IDLE while other requests are pending.
module eval_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic              z,
  output logic              busy
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StGrant, StAck} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] win_q, win_d;
  logic [3:0]      op_q, op_d;
  logic            z_q, z_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;

  logic [NREQ-1:0] cand;
  logic            hi_found, lo_found, found, take;
  logic [PtrW-1:0] pick_hi, pick_lo, pick;
  logic [3:0]      op_hi, op_lo, pick_op;

  // Candidate requests: the requester being acknowledged cannot win again.
  always_comb begin
    cand = req;
    if (state_q == StAck) begin
      cand = req & ~(NREQ'(1) << win_q);
    end
  end

  // Round-robin search: lowest index at or above the pointer, else lowest below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    op_hi    = '0;
    op_lo    = '0;
    // Descending scan so the last hit in each half is its lowest index.
    for (int j = int'(NREQ) - 1; j >= 0; j--) begin
      if (cand[j]) begin
        if (j >= int'(ptr_q)) begin
          hi_found = 1'b1;
          pick_hi  = PtrW'(j);
          op_hi    = data[4*j +: 4];
        end else begin
          lo_found = 1'b1;
          pick_lo  = PtrW'(j);
          op_lo    = data[4*j +: 4];
        end
      end
    end
    found   = hi_found | lo_found;
    pick    = hi_found ? pick_hi : pick_lo;
    pick_op = hi_found ? op_hi : op_lo;
  end

  // A new winner is taken from IDLE or straight out of ACK.
  assign take = found && ((state_q == StIdle) || (state_q == StAck));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = found ? StGrant : StIdle;
      StGrant: state_d = StAck;
      StAck:   state_d = found ? StGrant : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    ptr_d = ptr_q;
    win_d = win_q;
    op_d  = op_q;
    z_d   = z_q;
    gnt_d = gnt_q;
    ack_d = '0;
    if (take) begin
      win_d = pick;
      op_d  = pick_op;
      ptr_d = (pick == PtrW'(NREQ - 1)) ? '0 : pick + PtrW'(1);
      gnt_d = NREQ'(1) << pick;
    end else if (state_q == StAck) begin
      gnt_d = '0;
    end
    if (state_q == StGrant) begin
      // Evaluate the latched operand only; data is not re-sampled here.
      z_d   = (op_q[0] & op_q[1]) | op_q[2] | op_q[3];
      ack_d = gnt_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      win_q <= '0;
      op_q  <= '0;
      z_q   <= 1'b0;
      gnt_q <= '0;
      ack_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      win_q <= win_d;
      op_q  <= op_d;
      z_q   <= z_d;
      gnt_q <= gnt_d;
      ack_q <= ack_d;
    end
  end

  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign z    = z_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_eval_arbiter.sv
// Bench for eval_arbiter: directed scenarios followed by random traffic,
// all compared every cycle against a transaction-level reference model.
module tb_eval_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [4*N-1:0] data;
  logic [N-1:0] gnt, ack;
  logic         z, busy;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = no transaction, 1 = operand held, 2 = result shown.
  int         m_phase, m_g, m_p;
  logic [3:0] m_op;
  logic       m_z;

  int         ack_order[$];
  logic       z_order[$];
  logic [3:0] pats [3] = '{4'b1100, 4'b0001, 4'b0011};
  logic [3:0] zexp [3] = '{4'd1, 4'd0, 4'd1};

  eval_arbiter #(.NREQ(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .data (data),
    .gnt  (gnt),
    .ack  (ack),
    .z    (z),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int rr_pick(logic [N-1:0] r, int p, int excl);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (i != excl && r[i[1:0]]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_g     = 0;
    m_p     = 0;
    m_op    = 4'd0;
    m_z     = 1'b0;
  endtask

  task automatic model_start(int w);
    m_g     = w;
    m_op    = data[4*w +: 4];
    m_p     = (w + 1) % N;
    m_phase = 1;
  endtask

  task automatic model_step();
    int w;
    case (m_phase)
      0: begin
        w = rr_pick(req, m_p, -1);
        if (w >= 0) model_start(w);
      end
      1: begin
        // (d0&d1)|d2|d3 is true exactly when the operand value is 3 or more.
        m_z     = (m_op >= 4'd3);
        m_phase = 2;
      end
      default: begin
        w = rr_pick(req, m_p, m_g);
        if (w >= 0) model_start(w);
        else m_phase = 0;
      end
    endcase
  endtask

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] one, eg, ea;
    one = 1;
    eg  = (m_phase != 0) ? (one << m_g) : '0;
    ea  = (m_phase == 2) ? (one << m_g) : '0;
    chk("gnt", gnt, eg);
    chk("ack", ack, ea);
    chk("z", 4'(z), 4'(m_z));
    chk("busy", 4'(busy), (m_phase != 0) ? 4'd1 : 4'd0);
  endtask

  // Advance the model with the inputs present at the edge, then compare just after it.
  task automatic tick();
    if (rst_n) model_step();
    else model_reset();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '1;
    data  = 16'($urandom);
    model_reset();

    // Reset held for two cycles with requests pending.
    tick();
    tick();
    rst_n = 1'b1;
    req   = '0;
    tick();
    tick();

    // Single requester with three operand patterns.
    for (int t = 0; t < 3; t++) begin
      data = {12'h000, pats[t]};
      req  = 4'b0001;
      tick();
      chk("single_gnt", gnt, 4'b0001);
      tick();
      chk("single_ack", ack, 4'b0001);
      chk("single_z", 4'(z), zexp[t]);
      req = '0;
      tick();
      chk("single_idle", 4'(busy), 4'd0);
    end

    // All four requesting from reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req   = 4'b1111;
    data  = {4'b0011, 4'b0010, 4'b1000, 4'b0000};
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("all_busy", 4'(busy), 4'd1);
      if (ack != '0) begin
        for (int k = 0; k < N; k++) if (ack[k]) ack_order.push_back(k);
        z_order.push_back(z);
        req = req & ~ack;
      end
    end
    chk("all_count", 4'(ack_order.size()), 4'd4);
    if (ack_order.size() == 4 && z_order.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("all_order", 4'(ack_order[k]), 4'(k));
        chk("all_z", 4'(z_order[k]), 4'(k % 2));
      end
    end
    req = '0;
    tick();

    // Fairness: pointer wraps past index 3; a holder after its ack yields.
    req = 4'b0100;
    tick();
    chk("fair_gnt2", gnt, 4'b0100);
    req = 4'b0101;
    tick();
    chk("fair_ack2", ack, 4'b0100);
    tick();
    chk("fair_first", gnt, 4'b0001);
    tick();
    chk("fair_ack0", ack, 4'b0001);
    req = 4'b0100;
    tick();
    chk("fair_second", gnt, 4'b0100);
    req = '0;
    tick();
    tick();

    // Request dropped right after grant; operand changes after latching.
    data = 16'($urandom);
    data[7:4] = 4'b1111;
    req = 4'b0010;
    tick();
    chk("drop_gnt", gnt, 4'b0010);
    req  = '0;
    data = 16'h0000;
    tick();
    chk("drop_ack", ack, 4'b0010);
    chk("drop_z", 4'(z), 4'd1);
    tick();

    // Reset asserted mid-transaction clears everything at once.
    data = 16'($urandom);
    req  = 4'b0100;
    tick();
    chk("mid_gnt", gnt, 4'b0100);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_gnt", gnt, 4'b0000);
    chk("mid_rst_busy", 4'(busy), 4'd0);
    chk("mid_rst_z", 4'(z), 4'd0);
    tick();
    chk("mid_rst_noack", ack, 4'b0000);
    rst_n = 1'b1;
    req   = 4'b1010;
    tick();
    chk("post_reset_ptr", gnt, 4'b0010);
    req = '0;
    tick();
    tick();

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      req   = 4'($urandom);
      data  = 16'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eval_arbiter.md
# eval_arbiter

Round-robin scheduler that shares one registered evaluator among NREQ requesters. The evaluator computes Z = (d[0] & d[1]) | d[2] | d[3] on a 4-bit operand. The block arbitrates requests, latches the winner's operand, evaluates it, registers the result, and returns a one-cycle acknowledge to the winner. It sits between the per-channel request logic and the shared combinational/register datapath, so only one requester drives the evaluator at a time.

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- Clk  input  1  system clock; all state updates on rising edge
- Rst  input  1  asynchronous, active-low reset; 0 resets all state immediately
- Req  input  NREQ  request from requester i at bit i; level, held until Ack[i]
- Data  input  4*NREQ  operand of requester i at bits [4i+3:4i]; must be valid whenever Req[i]=1
- Gnt  output  NREQ  one-hot grant; bit g high from grant through acknowledge
- Ack  output  NREQ  one-hot, one-cycle pulse marking completion for requester g
- Z  output  1  registered evaluator result; valid while Ack is high, held until next completion
- Busy  output  1  high whenever state is not IDLE

## Operation
- Registers:
  - state: IDLE, GRANT or ACK.
  - Round-robin pointer P: log2(NREQ) bits.
  - Winner index g.
  - Operand register Op[3:0].
  - Result register Z.
- Arbitration:
  - Search Req starting at index P, ascending with wrap at NREQ-1 -> 0.
  - The first set bit wins.
  - On each grant, P <= (g+1) mod NREQ.
- IDLE:
  - If any Req bit is set, go to GRANT.
  - At the same edge: g <= winner, Op <= Data[4g+3:4g], Gnt <= one-hot(g).
  - Otherwise stay in IDLE with Gnt = 0.
- GRANT:
  - Evaluator operates on Op only; Data is not re-sampled.
  - Next edge: Z <= (Op[0]&Op[1])|Op[2]|Op[3], Ack[g] <= 1, go to ACK.
- ACK:
  - Arbitration uses Req with bit g masked, so the requester currently being acknowledged cannot win again.
  - If any masked request is set, go directly to GRANT with a new winner, latching its operand and grant as in IDLE.
  - Otherwise go to IDLE with Gnt <= 0.
  - Ack returns to 0 at this edge in either case.
- Req[g] deasserted during GRANT: the transaction still completes and Ack[g] still pulses. Requesters must not treat a dropped Req as a cancel.
- Req[g] still high in the cycle after Ack: treated as a new request, arbitrated normally from pointer P.
- Reset values:
  - state = IDLE, P = 0, g = 0, Op = 0.
  - Gnt = 0, Ack = 0, Z = 0, Busy = 0.
- Reset asserted mid-transaction: all registers clear immediately and asynchronously. No Ack is issued for the in-flight request; the requester re-requests after reset.

## Timing
- Request latency:
  - Req[i] high before edge k, while in IDLE -> Gnt[i] high after edge k.
  - Ack[i] and the new Z are valid after edge k+1, for exactly one cycle.
  - Gnt[i] falls after edge k+2 unless the next winner is also i (only possible via IDLE).
- Back-to-back throughput: 2 cycles per transaction (GRANT, ACK, GRANT, ...). No IDLE cycle between transactions while masked requests are pending.
- Ack is always a subset of Gnt. Gnt and Ack are never multi-hot.
- Z changes only on the GRANT->ACK edge or on reset.
- Busy = 1 in GRANT and ACK, 0 in IDLE.

## Test plan
- Reset: hold Rst=0 for 2 cycles with arbitrary Req -> Gnt=0, Ack=0, Z=0, Busy=0. After release with Req=0 -> outputs stay 0.
- Single requester, NREQ=4:
  - Req=0001, Data[3:0]=1100 -> Gnt=0001 after 1 edge; Ack=0001 with Z=1 after 2 edges.
  - Repeat with Data[3:0]=0001 -> Z=0.
  - Repeat with Data[3:0]=0011 -> Z=1.
- All four requesting from reset: Req=1111, held until each Ack, with Data = 0000, 1000, 0010, 0011 -> Ack order 0,1,2,3 on alternate cycles; Z = 0,1,0,1; Busy continuously high for 8 cycles.
- Fairness:
  - After granting index 2, assert Req=0101 -> index 0 wins next (P=3 wraps to 0), then index 2.
  - A requester holding Req after its Ack is not re-granted in the following GRANT while another request is pending.
- Req drop: deassert Req[1] the cycle after Gnt[1] rises -> Ack[1] still pulses once with the correct Z.
- Reset mid-op: assert Rst=0 during GRANT -> Gnt, Busy and Z go to 0 immediately; no Ack appears; the next request after release behaves as from reset, with P=0.
